seven_seg_capture: RTL and testbench

- Receiving end of the multiplexed seven-segment bus: samples active-low segment lines plus active-low digit enables and recovers one BCD value per digit.
- Used on the scoreboard path and in bench/loopback checks that read back what the display driver is showing.
- Filters scan glitches with a stability counter and flags patterns that are not legal digit glyphs.

---
 rtl/seven_seg_capture.sv | 204 ++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus receiver: recovers one BCD value per digit with glitch filtering.
// Optional decimal-point capture is enabled by defining SEG_CAPTURE_DP_EN.
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              lines,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    update,
    output logic                    frame_done
`ifdef SEG_CAPTURE_DP_EN
    ,
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG_CAPTURE_DP_EN
    localparam int unsigned PAT_W = 8;
`else
    localparam int unsigned PAT_W = 7;
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    state_t                  state, state_nx;
    logic [6:0]              s_lines;
    logic [NUM_DIGITS-1:0]   s_en;
    logic [PAT_W-1:0]        s_pat;
    logic [IDX_W-1:0]        s_idx;
    logic [3:0]              zeros;
    logic                    sel, blank, same;
    logic [IDX_W-1:0]        lat_idx, lat_idx_nx;
    logic [PAT_W-1:0]        lat_pat, lat_pat_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx, cnt_sat;
    logic [NUM_DIGITS-1:0]   mask, mask_set;
    logic [3:0]              dec_val;
    logic                    dec_wr, dec_err;

`ifdef SEG_CAPTURE_DP_EN
    logic s_dp;
    always_ff @(posedge clk) begin
        if (rst) s_dp <= 1'b1;
        else     s_dp <= dp;
    end
    assign s_pat = {s_dp, s_lines};
`else
    assign s_pat = s_lines;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s_lines <= '1;
            s_en    <= '1;
        end else begin
            s_lines <= lines;
            s_en    <= digit_en;
        end
    end

    always_comb begin
        zeros = '0;
        s_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_en[i]) begin
                zeros = zeros + 4'd1;
                s_idx = IDX_W'(i);
            end
        end
        sel   = (zeros == 4'd1);
        blank = (s_lines == 7'b1111111);
        same  = (s_idx == lat_idx) && (s_pat == lat_pat);
    end

    assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            lat_pat <= '1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lat_idx <= lat_idx_nx;
            lat_pat <= lat_pat_nx;
        end
    end

    // CAPTURE is entered on the sample that brings the count to STABLE_CYCLES,
    // so a capture lands STABLE_CYCLES+2 cycles after the inputs settle.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        lat_idx_nx = lat_idx;
        lat_pat_nx = lat_pat;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (sel && !blank) begin
                    lat_idx_nx = s_idx;
                    lat_pat_nx = s_pat;
                    cnt_nx     = CNT_W'(1);
                    state_nx   = SETTLE;
                end
            end
            SETTLE: begin
                if (!sel || blank) begin
                    state_nx = IDLE;
                end else if (same) begin
                    cnt_nx = cnt_sat;
                    if (cnt_sat == CNT_W'(STABLE_CYCLES)) state_nx = CAPTURE;
                end else begin
                    lat_idx_nx = s_idx;
                    lat_pat_nx = s_pat;
                    cnt_nx     = CNT_W'(1);
                end
            end
            CAPTURE: state_nx = HOLD;
            HOLD: begin
                if (!(sel && same)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dec_val = 4'h0;
        dec_wr  = 1'b1;
        dec_err = 1'b0;
        case (lat_pat[6:0])
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b0110000: begin
                dec_val = 4'hE;
                dec_err = 1'b1;
            end
            default: begin
                dec_wr  = 1'b0;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        mask_set = mask;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lat_idx == IDX_W'(i)) mask_set[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            digit_valid <= '0;
            err         <= '0;
            update      <= 1'b0;
            frame_done  <= 1'b0;
            mask        <= '0;
`ifdef SEG_CAPTURE_DP_EN
            dp_out      <= '0;
`endif
        end else begin
            update     <= 1'b0;
            frame_done <= 1'b0;
            if (state == CAPTURE) begin
                update <= 1'b1;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (lat_idx == IDX_W'(i)) begin
                        digit_valid[i] <= 1'b1;
                        err[i]         <= dec_err;
                        if (dec_wr) value[4*i +: 4] <= dec_val;
`ifdef SEG_CAPTURE_DP_EN
                        dp_out[i]      <= ~lat_pat[7];
`endif
                    end
                end
                if (mask_set == '1) begin
                    frame_done <= 1'b1;
                    mask       <= '0;
                end else begin
                    mask <= mask_set;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed self-checking bench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  lines;
    logic [3:0]  digit_en;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  err;
    logic        update;
    logic        frame_done;
`ifdef SEG_CAPTURE_DP_EN
    logic        dp = 1'b1;
    logic [3:0]  dp_out;
`endif

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lines(lines),
        .digit_en(digit_en),
        .value(value),
        .digit_valid(digit_valid),
        .err(err),
        .update(update),
        .frame_done(frame_done)
`ifdef SEG_CAPTURE_DP_EN
        ,
        .dp(dp),
        .dp_out(dp_out)
`endif
    );

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int fd_cnt = 0;
    int both_cnt = 0;
    int u0, f0, b0;

    logic [6:0] glyph [4];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (update) upd_cnt++;
            if (frame_done) fd_cnt++;
            if (update && frame_done) both_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        glyph[0] = 7'b1001111;
        glyph[1] = 7'b0010010;
        glyph[2] = 7'b0000110;
        glyph[3] = 7'b1001100;

        // reset during activity
        rst = 1'b1;
        digit_en = 4'b1110;
        lines = 7'b0000000;
        step(3);
        check("rst value", 32'(value), 32'h0);
        check("rst digit_valid", 32'(digit_valid), 32'h0);
        check("rst err", 32'(err), 32'h0);
        check("rst update", 32'(update), 32'h0);
        check("rst frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        digit_en = 4'b1111;
        lines = 7'b1111111;
        step(3);

        // digit 0 shows 2, update in cycle 10
        u0 = upd_cnt;
        digit_en = 4'b1110;
        lines = 7'b0010010;
        step(9);
        check("t1 no early update", 32'(upd_cnt - u0), 32'd0);
        step(1);
        check("t1 update at cycle 10", 32'(update), 32'h1);
        step(2);
        check("t1 single update", 32'(upd_cnt - u0), 32'd1);
        check("t1 value", 32'(value), 32'h0002);
        check("t1 digit_valid", 32'(digit_valid), 32'b0001);
        check("t1 err", 32'(err), 32'h0);

        // digit 1: short 3 then stable 4
        u0 = upd_cnt;
        digit_en = 4'b1101;
        lines = 7'b0000110;
        step(5);
        check("t2 no update on short glyph", 32'(upd_cnt - u0), 32'd0);
        lines = 7'b1001100;
        step(10);
        digit_en = 4'b1111;
        lines = 7'b1111111;
        step(4);
        check("t2 single update", 32'(upd_cnt - u0), 32'd1);
        check("t2 value", 32'(value), 32'h0042);
        check("t2 digit_valid", 32'(digit_valid), 32'b0011);

        // illegal pattern then error glyph on digit 0
        u0 = upd_cnt;
        digit_en = 4'b1110;
        lines = 7'b1111110;
        step(10);
        check("t3 illegal err", 32'(err), 32'b0001);
        check("t3 illegal value kept", 32'(value), 32'h0042);
        lines = 7'b0110000;
        step(12);
        check("t3 E glyph value", 32'(value), 32'h004E);
        check("t3 E glyph err", 32'(err), 32'b0001);
        digit_en = 4'b1111;
        lines = 7'b1111111;
        step(4);
        check("t3 update count", 32'(upd_cnt - u0), 32'd2);

        // no selection: two enables low, then none low
        u0 = upd_cnt;
        digit_en = 4'b1100;
        lines = 7'b0001111;
        step(20);
        digit_en = 4'b1111;
        step(20);
        check("t4 no update unselected", 32'(upd_cnt - u0), 32'd0);

        // reset mid-SETTLE
        digit_en = 4'b1011;
        lines = 7'b0001111;
        step(5);
        rst = 1'b1;
        digit_en = 4'b1111;
        lines = 7'b1111111;
        step(1);
        check("t4 rst value", 32'(value), 32'h0);
        check("t4 rst err", 32'(err), 32'h0);
        rst = 1'b0;
        u0 = upd_cnt;
        step(15);
        check("t4 no capture after rst", 32'(upd_cnt - u0), 32'd0);
        check("t4 digit_valid after rst", 32'(digit_valid), 32'h0);

        // two full scans 1,2,3,4
        u0 = upd_cnt;
        f0 = fd_cnt;
        b0 = both_cnt;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 4; d++) begin
                digit_en = ~(4'b0001 << d);
                lines = glyph[d];
                step(10);
            end
        end
        digit_en = 4'b1111;
        lines = 7'b1111111;
        step(5);
        check("t5 value", 32'(value), 32'h4321);
        check("t5 digit_valid", 32'(digit_valid), 32'b1111);
        check("t5 err", 32'(err), 32'h0);
        check("t5 update count", 32'(upd_cnt - u0), 32'd8);
        check("t5 frame_done count", 32'(fd_cnt - f0), 32'd2);
        check("t5 frame_done with update", 32'(both_cnt - b0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
